// File: rtl/rng_scheduler_pkg.sv
// Shared types and constants for the LFSR draw scheduler.
// State encoding, reset seed and the zero-seed substitute.
package rng_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARB     = 2'd1,
      STEP    = 2'd2,
      DELIVER = 2'd3
   } state_t;

   localparam logic [1:0] LFSR_SEED  = 2'b01;
   localparam logic [1:0] SEED_SUBST = 2'b01;

endpackage

// File: rtl/rng_scheduler_lfsr_step.sv
// 2-bit Fibonacci LFSR (period 3) with step enable and load.
// A zero load value is replaced so the register never locks at 00.
module lfsr_step
   import rng_scheduler_pkg::*;
#(
   parameter logic [1:0] SEED = LFSR_SEED
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       load,
   input  logic [1:0] load_val,
   output logic [1:0] lfsr
);

   localparam logic [1:0] RST_VAL = (SEED == 2'b00) ? SEED_SUBST : SEED;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr <= RST_VAL;
      end else if (load) begin
         lfsr <= (load_val == 2'b00) ? SEED_SUBST : load_val;
      end else if (step) begin
         lfsr <= {lfsr[0], lfsr[1] ^ lfsr[0]};
      end
   end

endmodule

// File: rtl/rng_scheduler.sv
// Round-robin draw scheduler for the shared 2-bit LFSR.
// Define RNG_FREE_RUN_EN to also advance the LFSR in IDLE and ARB.
module rng_scheduler
   import rng_scheduler_pkg::*;
#(
   parameter int         NUM_REQ = 4,
   parameter int         STEPS   = 2,
   parameter logic [1:0] SEED    = LFSR_SEED
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               reseed,
   input  logic [1:0]         seed_val,
   output logic [NUM_REQ-1:0] gnt,
   output logic [1:0]         rnd_out,
   output logic               valid,
   output logic               busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t          state, state_nx;
   logic [IW-1:0]   last, winner, pick, idx;
   logic            found;
   logic [2:0]      cnt;
   logic [1:0]      lfsr, rnd_q;
   logic            step_en;
   int              j;

   // Search starts just above the last winner so it gets lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = last;
      idx   = '0;
      j     = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         j   = (int'(last) + i) % NUM_REQ;
         idx = IW'(j);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (|req) state_nx = ARB;
         ARB:     state_nx = found ? STEP : IDLE;
         STEP:    if (cnt == 3'd1) state_nx = DELIVER;
         DELIVER: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         last   <= IW'(NUM_REQ - 1);
         winner <= '0;
         cnt    <= '0;
         rnd_q  <= '0;
      end else begin
         state <= state_nx;
         if (state == ARB && found) begin
            winner <= pick;
            cnt    <= 3'(STEPS);
         end
         if (state == STEP) cnt <= cnt - 3'd1;
         if (state == DELIVER) begin
            last  <= winner;
            rnd_q <= lfsr;
         end
      end
   end

`ifdef RNG_FREE_RUN_EN
   assign step_en = (state == STEP) || (state == IDLE) || (state == ARB);
`else
   assign step_en = (state == STEP);
`endif

   lfsr_step #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .step     (step_en),
      .load     (reseed),
      .load_val (seed_val),
      .lfsr     (lfsr)
   );

   assign valid   = (state == DELIVER);
   assign busy    = (state != IDLE);
   assign gnt     = valid ? (NUM_REQ'(1) << winner) : '0;
   assign rnd_out = valid ? lfsr : rnd_q;

endmodule
